// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: two-digit multiplexed common-anode 7-segment driver for a captured BCD sum.
// Optional macro BCD_SEG_ERR_BLINK_EN blinks the "Er" glyphs every BLINK_DIV scan periods.
module bcd_seg_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES = 2,
  parameter int BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] s1,
  input  logic [3:0] s0,
  input  logic       error,
  output logic [6:0] seg,
  output logic [1:0] an
);
  localparam int MAXC = REFRESH_DIV > GAP_CYCLES ? REFRESH_DIV : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] R_LD = CW'(REFRESH_DIV);
  localparam logic [CW-1:0] G_LD = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic [1:0] {SHOW0, GAP0, SHOW1, GAP1} state_t;
  if (REFRESH_DIV < 1 || GAP_CYCLES < 1 || BLINK_DIV < 1) begin : g_chk
    $error("bcd_seg_scanner: REFRESH_DIV, GAP_CYCLES and BLINK_DIV must be >= 1");
  end
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] d1_q, d1_d, d0_q, d0_d;
  logic err_q, err_d;
  logic [6:0] seg_q, seg_d, tens_g, units_g;
  logic [1:0] an_q, an_d;
  logic blank;
  function automatic logic [6:0] dig7(input logic [3:0] d);
    case (d)
      4'd0: dig7 = 7'h40;
      4'd1: dig7 = 7'h79;
      4'd2: dig7 = 7'h24;
      4'd3: dig7 = 7'h30;
      4'd4: dig7 = 7'h19;
      4'd5: dig7 = 7'h12;
      4'd6: dig7 = 7'h02;
      4'd7: dig7 = 7'h78;
      4'd8: dig7 = 7'h00;
      4'd9: dig7 = 7'h10;
      default: dig7 = 7'h3F;
    endcase
  endfunction
`ifdef BCD_SEG_ERR_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic phase_q, phase_d;
  // Periods are counted on the GAP1 -> SHOW0 wrap.
  always_comb begin
    bcnt_d = bcnt_q;
    phase_d = phase_q;
    if (state_q == GAP1 && cnt_q == ONE) begin
      bcnt_d = bcnt_q + BW'(1);
      if (bcnt_d == BW'(BLINK_DIV)) begin
        bcnt_d = '0;
        phase_d = !phase_q;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      bcnt_q <= '0;
      phase_q <= 1'b1;
    end else begin
      bcnt_q <= bcnt_d;
      phase_q <= phase_d;
    end
  assign blank = err_q && !phase_q;
`else
  assign blank = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q - ONE;
    if (cnt_q == ONE) begin
      state_d = state_t'(state_q + 2'd1);
      cnt_d = state_q[0] ? R_LD : G_LD;
    end
    d1_d = in_valid ? s1 : d1_q;
    d0_d = in_valid ? s0 : d0_q;
    err_d = in_valid ? error : err_q;
    tens_g = err_q ? 7'h06 : d1_q == 4'd0 ? 7'h7F : dig7(d1_q);
    units_g = err_q ? 7'h2F : dig7(d0_q);
    an_d = blank || state_q[0] ? 2'b11 : state_q == SHOW0 ? 2'b10 : 2'b01;
    seg_d = blank || state_q[0] ? 7'h7F : state_q == SHOW0 ? units_g : tens_g;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= SHOW0;
      cnt_q <= R_LD;
      d1_q <= '0;
      d0_q <= '0;
      err_q <= 1'b0;
      an_q <= 2'b11;
      seg_q <= 7'h7F;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      d1_q <= d1_d;
      d0_q <= d0_d;
      err_q <= err_d;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  assign an = an_q;
  assign seg = seg_q;
endmodule

// File: tb/tb_bcd_seg_scanner.sv
// tb_bcd_seg_scanner: randomized self-checking bench against a cycle-position reference model.
module tb_bcd_seg_scanner;
  localparam int R = 4;
  localparam int G = 1;
  localparam int B = 2;
  localparam int P = 2 * (R + G);
  logic clk, rst_n, in_valid, error;
  logic [3:0] s1, s0;
  logic [6:0] seg;
  logic [1:0] an;
  int n, pass_cnt, total_cnt;
  logic [3:0] m_d1, m_d0;
  logic m_err;
  logic [1:0] exp_an;
  logic [6:0] exp_seg;
  logic [6:0] digs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  bcd_seg_scanner #(.REFRESH_DIV(R), .GAP_CYCLES(G), .BLINK_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s1(s1), .s0(s0),
    .error(error), .seg(seg), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] m_glyph(input bit tens);
    logic [3:0] v;
    if (m_err) return tens ? 7'h06 : 7'h2F;
    v = tens ? m_d1 : m_d0;
    if (tens && v == 0) return 7'h7F;
    if (v > 9) return 7'h3F;
    return digs[v];
  endfunction

  // Advances one edge and derives the expected outputs from the cycle position since reset.
  task automatic tick(input bit r, input bit iv, input logic [3:0] a, input logic [3:0] b, input bit e);
    rst_n = r; in_valid = iv; s1 = a; s0 = b; error = e;
    @(posedge clk);
    #1;
    if (!r) begin
      n = 0; m_d1 = 0; m_d0 = 0; m_err = 0;
      exp_an = 2'b11; exp_seg = 7'h7F;
    end else begin
      int p;
      bit on;
      n++;
      p = (n - 1) % P;
      on = 1;
`ifdef BCD_SEG_ERR_BLINK_EN
      on = !(m_err && ((((n - 1) / P) / B) % 2 == 1));
`endif
      if (!on || (p >= R && p < R + G) || p >= 2 * R + G) begin
        exp_an = 2'b11; exp_seg = 7'h7F;
      end else if (p < R) begin
        exp_an = 2'b10; exp_seg = m_glyph(0);
      end else begin
        exp_an = 2'b01; exp_seg = m_glyph(1);
      end
      if (iv) begin
        m_d1 = a; m_d0 = b; m_err = e;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 4'd9, 4'd9, 1);
      total_cnt++;
      if ({an, seg} !== {2'b11, 7'h7F}) $display("FAIL reset an=%b seg=%h expected an=11 seg=7f", an, seg);
      else pass_cnt++;
    end
    tick(1, 0, 0, 0, 0);
    total_cnt++;
    if ({an, seg} !== {2'b10, 7'h40}) $display("FAIL reset_release an=%b seg=%h expected an=10 seg=40", an, seg);
    else pass_cnt++;
  endtask

  task automatic test_scan();
    for (int i = 0; i < 2 * P; i++) begin
      tick(1, 0, 0, 0, 0);
      total_cnt++;
      if ({an, seg} !== {exp_an, exp_seg}) $display("FAIL scan n=%0d an=%b seg=%h expected an=%b seg=%h", n, an, seg, exp_an, exp_seg);
      else pass_cnt++;
    end
  endtask

  task automatic test_digits(input logic [3:0] a, input logic [3:0] b);
    tick(1, 1, a, b, 0);
    for (int i = 0; i < P + 2; i++) begin
      tick(1, 0, 0, 0, 0);
      total_cnt++;
      if ({an, seg} !== {exp_an, exp_seg}) $display("FAIL digits_%0d%0d n=%0d an=%b seg=%h expected an=%b seg=%h", a, b, n, an, seg, exp_an, exp_seg);
      else pass_cnt++;
    end
  endtask

  task automatic test_error();
    tick(1, 1, 4'd1, 4'd3, 1);
    for (int i = 0; i < 5 * P; i++) begin
      tick(1, 0, 0, 0, 0);
      total_cnt++;
      if ({an, seg} !== {exp_an, exp_seg}) $display("FAIL error n=%0d an=%b seg=%h expected an=%b seg=%h", n, an, seg, exp_an, exp_seg);
      else pass_cnt++;
    end
    tick(1, 1, 4'd2, 4'd4, 0);
  endtask

  task automatic test_reset_mid();
    int k;
    tick(1, 1, 4'd7, 4'd7, 0);
    k = 0;
    while (n % P != R + G + 1 && k < 2 * P) begin
      tick(1, 0, 0, 0, 0);
      k++;
    end
    total_cnt++;
    if (k >= 2 * P) $display("FAIL reset_mid_seek n=%0d expected SHOW1 position", n);
    else pass_cnt++;
    tick(0, 0, 0, 0, 0);
    total_cnt++;
    if ({an, seg} !== {2'b11, 7'h7F}) $display("FAIL reset_mid an=%b seg=%h expected an=11 seg=7f", an, seg);
    else pass_cnt++;
    tick(1, 0, 0, 0, 0);
    total_cnt++;
    if ({an, seg} !== {2'b10, 7'h40}) $display("FAIL reset_mid_release an=%b seg=%h expected an=10 seg=40", an, seg);
    else pass_cnt++;
  endtask

  task automatic test_boundary();
    int k;
    k = 0;
    while ((n + 1) % P != R + G && k < 2 * P) begin
      tick(1, 0, 0, 0, 0);
      k++;
    end
    tick(1, 1, 4'd8, 4'd2, 0);
    for (int i = 0; i < P; i++) begin
      tick(1, 0, 0, 0, 0);
      total_cnt++;
      if ({an, seg} !== {exp_an, exp_seg}) $display("FAIL boundary n=%0d an=%b seg=%h expected an=%b seg=%h", n, an, seg, exp_an, exp_seg);
      else pass_cnt++;
      if (i == 0) begin
        total_cnt++;
        if ({an, seg} !== {2'b01, 7'h00}) $display("FAIL boundary_first_tens an=%b seg=%h expected an=01 seg=00", an, seg);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 59) != 0, $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      total_cnt++;
      if ({an, seg} !== {exp_an, exp_seg} || an === 2'b00) $display("FAIL random n=%0d an=%b seg=%h expected an=%b seg=%h", n, an, seg, exp_an, exp_seg);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; n = 0;
    m_d1 = 0; m_d0 = 0; m_err = 0;
    rst_n = 0; in_valid = 0; s1 = 0; s0 = 0; error = 0;
    test_reset();
    test_scan();
    test_digits(4'd1, 4'd5);
    test_digits(4'd0, 4'd9);
    test_digits(4'd12, 4'd10);
    test_error();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/bcd_seg_scanner.md
# bcd_seg_scanner

Downstream display stage for the single-digit BCD adder. Captures the two-digit BCD sum (tens, units) and the invalid-input flag, then time-multiplexes them onto a two-digit common-anode 7-segment display. A scan state machine inserts blanking gaps to prevent ghosting, suppresses a leading zero, and shows "Er" when the adder flags an error.

## Interface
- `REFRESH_DIV`, 50000: cycles each digit is lit per scan; ≥1.
- `GAP_CYCLES`, 2: all-digits-off cycles after each lit digit; ≥1.
- `BLINK_DIV`, 64: full scan periods per blink half-period; used only with the macro.

- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: capture strobe for `s1`, `s0`, `error`.
- `s1`  in  4: BCD tens digit.
- `s0`  in  4: BCD units digit.
- `error`  in  1: invalid-BCD-input flag.
- `seg`  out  7: segments `{g,f,e,d,c,b,a}`, active-low.
- `an`  out  2: digit enables, active-low; `an[0]` is units, `an[1]` is tens.

## Operation
- Capture register `{d1,d0,err}` loads on any edge with `in_valid`=1, with no ready/backpressure. Reset value is `{0,0,0}`.
- Scan FSM states and transitions:
  - `SHOW0` → `GAP0` after `REFRESH_DIV` cycles.
  - `GAP0` → `SHOW1` after `GAP_CYCLES` cycles.
  - `SHOW1` → `GAP1` after `REFRESH_DIV` cycles.
  - `GAP1` → `SHOW0` after `GAP_CYCLES` cycles.
  - One down-counter is reloaded on every state entry. Period is 2·(`REFRESH_DIV`+`GAP_CYCLES`) cycles.
- Counter width is `$clog2(max(REFRESH_DIV,GAP_CYCLES)+1)`; the counter never wraps.
- Digit enables: `SHOW0` drives `an`=2'b10, `SHOW1` drives 2'b01, gap states drive 2'b11.
- Segment codes, hex, active-low:
  - Digits 0–9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10.
  - Other glyphs: blank 7F, "E" 06, "r" 2F, dash 3F.
- Glyph selection:
  - `err`=1: tens shows "E" and units shows "r", whatever the digit values.
  - Else tens: `d1`=0 shows blank (leading-zero suppression), 1–9 shows the digit, >9 shows a dash.
  - Else units: 0–9 shows the digit, >9 shows a dash. Units 0 is never blanked.
- During gap states `seg` is 7F.
- A capture mid-scan does not disturb the FSM or counter. The new glyph appears from the next output update.

## Timing
- `seg` and `an` are registered. They reflect the FSM state and capture register as of the previous edge, so outputs lag the state by 1 cycle.
- Capture-to-display latency is 2 edges (capture edge, then output edge) if the FSM is in a SHOW state for the targeted digit.
- Reset, while `rst_n`=0 at an edge:
  - FSM goes to `SHOW0` with the counter reloaded to `REFRESH_DIV`.
  - Capture register clears.
  - `an`=2'b11 and `seg`=7F.
- Reset mid-scan or mid-blink aborts immediately with the same values.
- First edge with `rst_n`=1: `an`=2'b10 and `seg`=40 (units "0"). Tens is blank because `d1`=0.
- `in_valid`=1 during reset is ignored; reset wins.
- `an` is never 2'b00. Exactly one digit or none is enabled in any cycle.

## Configuration
- `BCD_SEG_ERR_BLINK_EN` defined:
  - A scan-period counter toggles a blink phase every `BLINK_DIV` periods, counted at `GAP1`→`SHOW0`. Reset phase is on.
  - While `err`=1 and phase is off, `an`=2'b11 and `seg`=7F.
  - Phase keeps running when `err`=0 but has no effect.
  - A capture that clears `err` restores normal display at the next output update.
- Macro undefined: no blink logic; "Er" displays steadily.

## Test plan
- Reset, then release with `REFRESH_DIV`=4, `GAP_CYCLES`=1 → `an` sequence 10×4, 11×1, 01×4, 11×1, repeating. `seg`=40 during units, 7F during tens.
- Capture `s1`=1, `s0`=5 → tens `seg`=79, units `seg`=12 within 2 edges of the next matching SHOW state.
- Capture `s1`=0, `s0`=9 → tens blank 7F, units 10.
- Capture `error`=1 with `s1`=1, `s0`=3 → tens 06 and units 2F. With the macro and `BLINK_DIV`=2, `an` stays 11 for alternate 2-period windows.
- Drop `rst_n` for one edge mid-`SHOW1` with a digit displayed → `an`=11 and `seg`=7F at that edge. Next edge `an`=10 and `seg`=40.
- Pulse `in_valid` in the same cycle as `GAP0`→`SHOW1` → no lost or extra scan cycles, and tens shows the new value at its first lit cycle.
